id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage, directly upstream of the ALU.
//  - Latches decoded operands and control, applies MEM/WB forwarding, drives Src1/Src2/ALUop.
//  - Handles stall/flush bubbles and flags load-use hazards back to decode.
// PARAMETERS
//  XLEN      32  datapath width
//  REGIDX_W  5   register index width
// PORTS
//  clk          in   1         clock, rising edge
//  reset        in   1         asynchronous, active-high reset
//  Stall        in   1         hold all E-stage registers
//  Flush        in   1         load a bubble into E-stage
//  D_valid      in   1         decode slot holds a real instruction
//  D_Rs1Val     in   XLEN      rs1 value read from the register file
//  D_Rs2Val     in   XLEN      rs2 value read from the register file
//  D_Imm        in   XLEN      sign-extended immediate
//  D_PC         in   XLEN      instruction PC
//  D_Rs1Idx     in   REGIDX_W  rs1 index
//  D_Rs2Idx     in   REGIDX_W  rs2 index
//  D_RdIdx      in   REGIDX_W  rd index
//  D_ALUop      in   4         ALU operation code
//  D_Src1PC     in   1         Src1 = PC instead of rs1
//  D_Src2Imm    in   1         Src2 = Imm instead of rs2
//  D_RegWrite   in   1         instruction writes rd
//  D_MemRead    in   1         instruction is a load
//  M_RdIdx      in   REGIDX_W  MEM-stage rd index
//  M_RegWrite   in   1         MEM-stage writes rd
//  M_Result     in   XLEN      MEM-stage ALU result
//  W_RdIdx      in   REGIDX_W  WB-stage rd index
//  W_RegWrite   in   1         WB-stage writes rd
//  W_Result     in   XLEN      WB-stage write-back data
//  Src1         out  XLEN      ALU source 1
//  Src2         out  XLEN      ALU source 2
//  ALUop        out  4         ALU operation code
//  E_valid      out  1         E-stage holds a real instruction
//  E_RdIdx      out  REGIDX_W  E-stage rd index
//  E_RegWrite   out  1         E-stage writes rd
//  E_MemRead    out  1         E-stage is a load
//  E_StoreData  out  XLEN      forwarded rs2 value, for stores
//  LoadUseHaz   out  1         combinational stall request to decode
// BEHAVIOUR
//  - Reset (async, any time, including mid-operation): all E registers clear to 0.
//    Outputs then read E_valid=0, RegWrite=0, MemRead=0, ALUop=4'h0, Src1=Src2=E_StoreData=0, LoadUseHaz=0.
//  - Each rising edge, by priority:
//    1. Flush=1: bubble. All control and index registers clear to 0; data registers clear to 0. Flush wins over Stall.
//    2. Stall=1: hold every register.
//    3. Otherwise: capture all D_* inputs.
//  - Latency: D_* values captured at edge N appear on outputs after edge N; no further cycles.
//  - Forwarding is combinational on the registered indices, applied separately for rs1 and rs2:
//    - If M_RegWrite && M_RdIdx==rsIdx && rsIdx!=0, use M_Result.
//    - Else if W_RegWrite && W_RdIdx==rsIdx && rsIdx!=0, use W_Result.
//    - Else use the registered value. MEM always beats WB.
//  - Src1 = E_Src1PC ? E_PC : fwd_rs1.
//  - Src2 = E_Src2Imm ? E_Imm : fwd_rs2.
//  - E_StoreData = fwd_rs2 regardless of Src2Imm.
//  - Bubbles carry index 0, so a bubble is never forwarded into and never forwards out.
//  - LoadUseHaz = D_valid && E_valid && E_MemRead && E_RdIdx!=0 && (E_RdIdx==D_Rs1Idx || E_RdIdx==D_Rs2Idx).
//    The hazard unit responds by raising Stall on decode and Flush here.
//  - No arithmetic is done in this block; widths pass through unchanged.
// CONFIGURATION
//  EX_FWD_EN defined (default build):
//  - Forwarding muxes present as above; LoadUseHaz covers loads only.
//  EX_FWD_EN undefined:
//  - No forwarding: fwd_rsN = registered rsN value; M_Result/W_Result are unused.
//  - LoadUseHaz widens to any RAW hazard: a decode rs index (nonzero) matching E_RdIdx with E_RegWrite, or M_RdIdx with M_RegWrite.
// TESTING
//  1. Assert reset mid-stream with E_valid=1 -> same cycle: all outputs 0, E_valid=0.
//  2. Capture D_Rs1Val=5, D_Imm=7, D_Src2Imm=1, D_ALUop=4'h0 -> next cycle: Src1=5, Src2=7, ALUop=4'h0.
//  3. E rs1Idx=3, M_RdIdx=3 with M_Result=0xAA, W_RdIdx=3 with W_Result=0xBB (both RegWrite) -> Src1=0xAA; drop M_RegWrite -> Src1=0xBB.
//  4. E rs1Idx=0 with stored value 0, M_RdIdx=0, M_RegWrite=1, M_Result=0x55 -> Src1 stays 0.
//  5. Stall=1 and Flush=1 on the same edge -> E_valid=0, E_RegWrite=0; Stall alone for 3 cycles -> outputs unchanged.
//  6. E_MemRead=1, E_RdIdx=4, D_Rs2Idx=4, D_valid=1 -> LoadUseHaz=1; change D_Rs2Idx to 0 -> LoadUseHaz=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundles the decode-side, forwarding-side and ALU-side signals of the ID/EX stage.
// master: the surrounding pipeline (drives D_*, M_*, W_*, Stall, Flush; reads E-stage outputs).
// slave:  the ID/EX stage itself.
interface id_ex_stage_if #(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
);
    logic                Stall;
    logic                Flush;
    logic                D_valid;
    logic [XLEN-1:0]     D_Rs1Val;
    logic [XLEN-1:0]     D_Rs2Val;
    logic [XLEN-1:0]     D_Imm;
    logic [XLEN-1:0]     D_PC;
    logic [REGIDX_W-1:0] D_Rs1Idx;
    logic [REGIDX_W-1:0] D_Rs2Idx;
    logic [REGIDX_W-1:0] D_RdIdx;
    logic [3:0]          D_ALUop;
    logic                D_Src1PC;
    logic                D_Src2Imm;
    logic                D_RegWrite;
    logic                D_MemRead;
    logic [REGIDX_W-1:0] M_RdIdx;
    logic                M_RegWrite;
    logic [XLEN-1:0]     M_Result;
    logic [REGIDX_W-1:0] W_RdIdx;
    logic                W_RegWrite;
    logic [XLEN-1:0]     W_Result;
    logic [XLEN-1:0]     Src1;
    logic [XLEN-1:0]     Src2;
    logic [3:0]          ALUop;
    logic                E_valid;
    logic [REGIDX_W-1:0] E_RdIdx;
    logic                E_RegWrite;
    logic                E_MemRead;
    logic [XLEN-1:0]     E_StoreData;
    logic                LoadUseHaz;

    modport master (
        output Stall, Flush, D_valid, D_Rs1Val, D_Rs2Val, D_Imm, D_PC,
               D_Rs1Idx, D_Rs2Idx, D_RdIdx, D_ALUop, D_Src1PC, D_Src2Imm,
               D_RegWrite, D_MemRead, M_RdIdx, M_RegWrite, M_Result,
               W_RdIdx, W_RegWrite, W_Result,
        input  Src1, Src2, ALUop, E_valid, E_RdIdx, E_RegWrite, E_MemRead,
               E_StoreData, LoadUseHaz
    );

    modport slave (
        input  Stall, Flush, D_valid, D_Rs1Val, D_Rs2Val, D_Imm, D_PC,
               D_Rs1Idx, D_Rs2Idx, D_RdIdx, D_ALUop, D_Src1PC, D_Src2Imm,
               D_RegWrite, D_MemRead, M_RdIdx, M_RegWrite, M_Result,
               W_RdIdx, W_RegWrite, W_Result,
        output Src1, Src2, ALUop, E_valid, E_RdIdx, E_RegWrite, E_MemRead,
               E_StoreData, LoadUseHaz
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register + operand select: latches decode, forwards MEM/WB results, drives ALU sources.
// Latency: one cycle from D_* capture to E outputs; forwarding and LoadUseHaz are combinational.
// Backpressure: Stall holds every E register, Flush (wins over Stall) loads a zero bubble.
// Ports: clk, reset (async active-high), bus (id_ex_stage_if.slave).
// Build option: EX_FWD_EN enables the MEM/WB forwarding muxes; without it no forwarding is done and
// LoadUseHaz widens to every RAW hazard against the E and M stages.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     rs1_val;
        logic [XLEN-1:0]     rs2_val;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
        logic [REGIDX_W-1:0] rs1_idx;
        logic [REGIDX_W-1:0] rs2_idx;
        logic [REGIDX_W-1:0] rd_idx;
        logic [3:0]          alu_op;
        logic                src1_pc;
        logic                src2_imm;
        logic                reg_write;
        logic                mem_read;
    } e_regs_t;

    e_regs_t         e_q;
    e_regs_t         d_in;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    always_comb begin
        d_in.valid     = bus.D_valid;
        d_in.rs1_val   = bus.D_Rs1Val;
        d_in.rs2_val   = bus.D_Rs2Val;
        d_in.imm       = bus.D_Imm;
        d_in.pc        = bus.D_PC;
        d_in.rs1_idx   = bus.D_Rs1Idx;
        d_in.rs2_idx   = bus.D_Rs2Idx;
        d_in.rd_idx    = bus.D_RdIdx;
        d_in.alu_op    = bus.D_ALUop;
        d_in.src1_pc   = bus.D_Src1PC;
        d_in.src2_imm  = bus.D_Src2Imm;
        d_in.reg_write = bus.D_RegWrite;
        d_in.mem_read  = bus.D_MemRead;
    end

    // A bubble is all-zero, so it carries index 0 and can neither forward nor be forwarded into.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
        end else if (bus.Flush) begin
            e_q <= '0;
        end else if (!bus.Stall) begin
            e_q <= d_in;
        end
    end

`ifdef EX_FWD_EN
    // MEM is younger than WB, so it is checked first; register x0 is never forwarded.
    always_comb begin
        fwd_rs1 = e_q.rs1_val;
        if (bus.M_RegWrite && bus.M_RdIdx == e_q.rs1_idx && e_q.rs1_idx != '0)
            fwd_rs1 = bus.M_Result;
        else if (bus.W_RegWrite && bus.W_RdIdx == e_q.rs1_idx && e_q.rs1_idx != '0)
            fwd_rs1 = bus.W_Result;

        fwd_rs2 = e_q.rs2_val;
        if (bus.M_RegWrite && bus.M_RdIdx == e_q.rs2_idx && e_q.rs2_idx != '0)
            fwd_rs2 = bus.M_Result;
        else if (bus.W_RegWrite && bus.W_RdIdx == e_q.rs2_idx && e_q.rs2_idx != '0)
            fwd_rs2 = bus.W_Result;
    end

    // Only a load in E cannot be covered by forwarding next cycle.
    assign bus.LoadUseHaz = bus.D_valid && e_q.valid && e_q.mem_read && e_q.rd_idx != '0 &&
                            (e_q.rd_idx == bus.D_Rs1Idx || e_q.rd_idx == bus.D_Rs2Idx);
`else
    assign fwd_rs1 = e_q.rs1_val;
    assign fwd_rs2 = e_q.rs2_val;

    // Without forwarding, decode must wait for any producer still in E or M; WB is assumed
    // to be visible through the register file's write-before-read.
    logic rs1_raw;
    logic rs2_raw;
    assign rs1_raw = bus.D_Rs1Idx != '0 &&
                     ((e_q.valid && e_q.reg_write && e_q.rd_idx == bus.D_Rs1Idx) ||
                      (bus.M_RegWrite && bus.M_RdIdx == bus.D_Rs1Idx));
    assign rs2_raw = bus.D_Rs2Idx != '0 &&
                     ((e_q.valid && e_q.reg_write && e_q.rd_idx == bus.D_Rs2Idx) ||
                      (bus.M_RegWrite && bus.M_RdIdx == bus.D_Rs2Idx));
    assign bus.LoadUseHaz = bus.D_valid && (rs1_raw || rs2_raw);

    wire unused_fwd_inputs = ^{bus.M_Result, bus.W_Result, bus.W_RdIdx, bus.W_RegWrite,
                               e_q.mem_read};
`endif

    assign bus.Src1        = e_q.src1_pc  ? e_q.pc  : fwd_rs1;
    assign bus.Src2        = e_q.src2_imm ? e_q.imm : fwd_rs2;
    assign bus.E_StoreData = fwd_rs2;
    assign bus.ALUop       = e_q.alu_op;
    assign bus.E_valid     = e_q.valid;
    assign bus.E_RdIdx     = e_q.rd_idx;
    assign bus.E_RegWrite  = e_q.reg_write;
    assign bus.E_MemRead   = e_q.mem_read;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors with literal expectations plus a per-cycle compare
// against an instruction-record model of the E stage.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    id_ex_stage_if #(.XLEN(32), .REGIDX_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .REGIDX_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: the instruction record currently occupying E (all-zero record = bubble).
    logic        mv_valid, mv_src1pc, mv_src2imm, mv_regwrite, mv_memread;
    logic [31:0] mv_rs1val, mv_rs2val, mv_imm, mv_pc;
    logic [4:0]  mv_rs1idx, mv_rs2idx, mv_rdidx;
    logic [3:0]  mv_aluop;

    always @(posedge clk or posedge reset) begin
        if (reset || bus.Flush) begin
            mv_valid <= 0; mv_src1pc <= 0; mv_src2imm <= 0; mv_regwrite <= 0; mv_memread <= 0;
            mv_rs1val <= 0; mv_rs2val <= 0; mv_imm <= 0; mv_pc <= 0;
            mv_rs1idx <= 0; mv_rs2idx <= 0; mv_rdidx <= 0; mv_aluop <= 0;
        end else if (!bus.Stall) begin
            mv_valid <= bus.D_valid; mv_src1pc <= bus.D_Src1PC; mv_src2imm <= bus.D_Src2Imm;
            mv_regwrite <= bus.D_RegWrite; mv_memread <= bus.D_MemRead;
            mv_rs1val <= bus.D_Rs1Val; mv_rs2val <= bus.D_Rs2Val; mv_imm <= bus.D_Imm;
            mv_pc <= bus.D_PC; mv_rs1idx <= bus.D_Rs1Idx; mv_rs2idx <= bus.D_Rs2Idx;
            mv_rdidx <= bus.D_RdIdx; mv_aluop <= bus.D_ALUop;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] val);
        logic [31:0] r;
        r = val;
`ifdef EX_FWD_EN
        if (idx != 0 && bus.M_RegWrite && bus.M_RdIdx == idx) r = bus.M_Result;
        else if (idx != 0 && bus.W_RegWrite && bus.W_RdIdx == idx) r = bus.W_Result;
`endif
        return r;
    endfunction

    function automatic logic depends_on(input logic [4:0] producer);
        return producer != 0 && (producer == bus.D_Rs1Idx || producer == bus.D_Rs2Idx);
    endfunction

    // Every negedge: outputs are settled and away from the capturing edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] op1, op2;
            logic        haz;
            op1 = operand(mv_rs1idx, mv_rs1val);
            op2 = operand(mv_rs2idx, mv_rs2val);
`ifdef EX_FWD_EN
            haz = bus.D_valid && mv_valid && mv_memread && depends_on(mv_rdidx);
`else
            haz = bus.D_valid && ((mv_valid && mv_regwrite && depends_on(mv_rdidx)) ||
                                  (bus.M_RegWrite && depends_on(bus.M_RdIdx)));
`endif
            chk("cyc_src1", bus.Src1, mv_src1pc ? mv_pc : op1);
            chk("cyc_src2", bus.Src2, mv_src2imm ? mv_imm : op2);
            chk("cyc_store", bus.E_StoreData, op2);
            chk("cyc_aluop", {28'd0, bus.ALUop}, {28'd0, mv_aluop});
            chk("cyc_valid", {31'd0, bus.E_valid}, {31'd0, mv_valid});
            chk("cyc_rd", {27'd0, bus.E_RdIdx}, {27'd0, mv_rdidx});
            chk("cyc_rw", {31'd0, bus.E_RegWrite}, {31'd0, mv_regwrite});
            chk("cyc_mr", {31'd0, bus.E_MemRead}, {31'd0, mv_memread});
            chk("cyc_haz", {31'd0, bus.LoadUseHaz}, {31'd0, haz});
        end
    end

    task automatic clear_inputs();
        bus.Stall = 0; bus.Flush = 0; bus.D_valid = 0;
        bus.D_Rs1Val = 0; bus.D_Rs2Val = 0; bus.D_Imm = 0; bus.D_PC = 0;
        bus.D_Rs1Idx = 0; bus.D_Rs2Idx = 0; bus.D_RdIdx = 0; bus.D_ALUop = 0;
        bus.D_Src1PC = 0; bus.D_Src2Imm = 0; bus.D_RegWrite = 0; bus.D_MemRead = 0;
        bus.M_RdIdx = 0; bus.M_RegWrite = 0; bus.M_Result = 0;
        bus.W_RdIdx = 0; bus.W_RegWrite = 0; bus.W_Result = 0;
    endtask

    // Advance past the next rising edge; inputs change 2 time units after it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clear_inputs();
        cyc();
        chk_en = 1'b1;
        chk("rst_valid", {31'd0, bus.E_valid}, 32'd0);
        chk("rst_src1", bus.Src1, 32'd0);
        reset = 0;

        // Immediate operand path.
        bus.D_valid = 1; bus.D_Rs1Idx = 1; bus.D_Rs1Val = 5; bus.D_Imm = 7;
        bus.D_Src2Imm = 1; bus.D_ALUop = 4'h0; bus.D_RdIdx = 2; bus.D_Rs2Val = 9;
        cyc();
        chk("imm_src1", bus.Src1, 32'd5);
        chk("imm_src2", bus.Src2, 32'd7);
        chk("imm_alu", {28'd0, bus.ALUop}, 32'd0);
        chk("imm_store", bus.E_StoreData, 32'd9);

        // MEM beats WB; then WB alone.
        bus.D_Rs1Idx = 3; bus.D_Rs1Val = 32'h11; bus.D_Src2Imm = 0; bus.D_ALUop = 4'h2;
        cyc();
        bus.M_RdIdx = 3; bus.M_RegWrite = 1; bus.M_Result = 32'hAA;
        bus.W_RdIdx = 3; bus.W_RegWrite = 1; bus.W_Result = 32'hBB;
        #1;
`ifdef EX_FWD_EN
        chk("fwd_mem", bus.Src1, 32'hAA);
`else
        chk("fwd_mem", bus.Src1, 32'h11);
`endif
        bus.M_RegWrite = 0;
        #1;
`ifdef EX_FWD_EN
        chk("fwd_wb", bus.Src1, 32'hBB);
`else
        chk("fwd_wb", bus.Src1, 32'h11);
`endif
        bus.W_RegWrite = 0;

        // x0 is never forwarded.
        bus.D_Rs1Idx = 0; bus.D_Rs1Val = 0;
        cyc();
        bus.M_RdIdx = 0; bus.M_RegWrite = 1; bus.M_Result = 32'h55;
        #1;
        chk("x0_nofwd", bus.Src1, 32'd0);
        bus.M_RegWrite = 0;

        // PC as source 1.
        bus.D_Src1PC = 1; bus.D_PC = 32'h1000;
        cyc();
        chk("pc_src1", bus.Src1, 32'h1000);
        bus.D_Src1PC = 0;

        // Flush wins over Stall.
        bus.D_RegWrite = 1; bus.D_ALUop = 4'h5;
        cyc();
        bus.Stall = 1; bus.Flush = 1;
        cyc();
        chk("flush_valid", {31'd0, bus.E_valid}, 32'd0);
        chk("flush_rw", {31'd0, bus.E_RegWrite}, 32'd0);
        chk("flush_alu", {28'd0, bus.ALUop}, 32'd0);
        bus.Stall = 0; bus.Flush = 0;
        bus.D_Rs1Idx = 1; bus.D_Rs1Val = 32'h33; bus.D_ALUop = 4'h9; bus.D_RdIdx = 6;
        cyc();
        bus.Stall = 1;
        bus.D_Rs1Val = 32'h77; bus.D_ALUop = 4'h1; bus.D_RdIdx = 7; bus.D_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_alu", {28'd0, bus.ALUop}, 32'h9);
            chk("stall_src1", bus.Src1, 32'h33);
            chk("stall_rd", {27'd0, bus.E_RdIdx}, 32'd6);
            chk("stall_valid", {31'd0, bus.E_valid}, 32'd1);
        end
        bus.Stall = 0;

        // Load-use hazard.
        bus.D_valid = 1; bus.D_MemRead = 1; bus.D_RdIdx = 4; bus.D_RegWrite = 1; bus.D_Rs1Idx = 0;
        cyc();
        bus.D_MemRead = 0; bus.D_Rs2Idx = 4; bus.D_Rs1Idx = 0;
        #1;
        chk("luh_hit", {31'd0, bus.LoadUseHaz}, 32'd1);
        bus.D_Rs2Idx = 0;
        #1;
        chk("luh_miss", {31'd0, bus.LoadUseHaz}, 32'd0);
        bus.D_Rs1Idx = 4; bus.D_valid = 0;
        #1;
        chk("luh_dinvalid", {31'd0, bus.LoadUseHaz}, 32'd0);
        bus.D_valid = 1; bus.D_Rs1Idx = 0;
        // ALU producer (not a load) in E now.
        bus.D_RdIdx = 8; bus.D_MemRead = 0;
        cyc();
        bus.D_Rs1Idx = 8;
        #1;
`ifdef EX_FWD_EN
        chk("raw_alu", {31'd0, bus.LoadUseHaz}, 32'd0);
`else
        chk("raw_alu", {31'd0, bus.LoadUseHaz}, 32'd1);
`endif

        // Asynchronous reset mid-stream while E holds an instruction.
        chk("pre_rst_valid", {31'd0, bus.E_valid}, 32'd1);
        reset = 1;
        #1;
        chk("arst_valid", {31'd0, bus.E_valid}, 32'd0);
        chk("arst_rw", {31'd0, bus.E_RegWrite}, 32'd0);
        chk("arst_mr", {31'd0, bus.E_MemRead}, 32'd0);
        chk("arst_alu", {28'd0, bus.ALUop}, 32'd0);
        chk("arst_src1", bus.Src1, 32'd0);
        chk("arst_src2", bus.Src2, 32'd0);
        chk("arst_store", bus.E_StoreData, 32'd0);
        chk("arst_haz", {31'd0, bus.LoadUseHaz}, 32'd0);
        cyc();
        reset = 0;

        // Mixed traffic with small index space so forwarding and hazards hit often.
        for (int i = 0; i < 400; i++) begin
            cyc();
            bus.Stall = ($urandom_range(0, 3) == 0);
            bus.Flush = ($urandom_range(0, 7) == 0);
            bus.D_valid = $urandom_range(0, 1);
            bus.D_Rs1Val = $urandom; bus.D_Rs2Val = $urandom;
            bus.D_Imm = $urandom; bus.D_PC = $urandom;
            bus.D_Rs1Idx = 5'($urandom_range(0, 3)); bus.D_Rs2Idx = 5'($urandom_range(0, 3));
            bus.D_RdIdx = 5'($urandom_range(0, 3)); bus.D_ALUop = 4'($urandom);
            bus.D_Src1PC = $urandom_range(0, 1); bus.D_Src2Imm = $urandom_range(0, 1);
            bus.D_RegWrite = $urandom_range(0, 1); bus.D_MemRead = $urandom_range(0, 1);
            bus.M_RdIdx = 5'($urandom_range(0, 3)); bus.M_RegWrite = $urandom_range(0, 1);
            bus.M_Result = $urandom;
            bus.W_RdIdx = 5'($urandom_range(0, 3)); bus.W_RegWrite = $urandom_range(0, 1);
            bus.W_Result = $urandom;
            reset = ($urandom_range(0, 49) == 0);
        end
        reset = 0;
        cyc();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
